// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory-side signals of the shared memory port arbiter.
// The slave modport is the arbiter's view; master is the pipeline/memory environment's view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 32
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_flush;
    logic              fetch_ready;
    logic [DATA_W-1:0] fetch_rdata;
    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_ready;
    logic [DATA_W-1:0] data_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_read_value;
    logic              busy;

    modport slave (
        input  fetch_req, fetch_addr, fetch_flush,
        input  data_req, data_we, data_addr, data_wdata,
        input  mem_read_value,
        output fetch_ready, fetch_rdata, data_ready, data_rdata,
        output mem_address, mem_we, mem_wdata, busy
    );

    modport master (
        output fetch_req, fetch_addr, fetch_flush,
        output data_req, data_we, data_addr, data_wdata,
        output mem_read_value,
        input  fetch_ready, fetch_rdata, data_ready, data_rdata,
        input  mem_address, mem_we, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and load/store,
// data first with a starvation limit, dropping responses of flushed fetches.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned STARVE_MAX  = 4
) (
    input  logic              clk,
    input  logic              rst_async,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned LAT_W    = $clog2(MEM_LATENCY + 1);
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_D} state_t;

    state_t              r_state;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic [STARVE_W-1:0] r_starve_cnt;
    logic                r_cancel;
    logic                r_is_write;
    logic [ADDR_W-1:0]   r_mem_address;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_mem_we;
    logic                r_busy;
    logic                r_fetch_ready;
    logic [DATA_W-1:0]   r_fetch_rdata;
    logic                r_data_ready;
    logic [DATA_W-1:0]   r_data_rdata;

    logic w_fetch_live;
    logic w_starved;
    logic w_grant_f;
    logic w_grant_d;
    logic w_last;

    always_comb begin
        w_fetch_live = bus.fetch_req && !bus.fetch_flush;
        w_starved    = (r_starve_cnt == STARVE_W'(STARVE_MAX));
        w_grant_f    = (r_state == IDLE) && w_fetch_live && (!bus.data_req || w_starved);
        w_grant_d    = (r_state == IDLE) && !w_grant_f && bus.data_req;
        w_last       = (r_lat_cnt == LAT_W'(1));
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_state       <= IDLE;
            r_lat_cnt     <= '0;
            r_starve_cnt  <= '0;
            r_cancel      <= 1'b0;
            r_is_write    <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_mem_we      <= 1'b0;
            r_busy        <= 1'b0;
            r_fetch_ready <= 1'b0;
            r_fetch_rdata <= '0;
            r_data_ready  <= 1'b0;
            r_data_rdata  <= '0;
        end else begin
            r_fetch_ready <= 1'b0;
            r_data_ready  <= 1'b0;
            r_mem_we      <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_grant_f) begin
                        r_state       <= BUSY_F;
                        r_lat_cnt     <= LAT_W'(MEM_LATENCY);
                        r_mem_address <= bus.fetch_addr;
                        r_mem_wdata   <= '0;
                        r_is_write    <= 1'b0;
                        r_busy        <= 1'b1;
                    end else if (w_grant_d) begin
                        r_state       <= BUSY_D;
                        r_lat_cnt     <= LAT_W'(MEM_LATENCY);
                        r_mem_address <= bus.data_addr;
                        r_mem_wdata   <= bus.data_wdata;
                        r_mem_we      <= bus.data_we;
                        r_is_write    <= bus.data_we;
                        r_busy        <= 1'b1;
                    end
                    // A flushed-but-held fetch neither counts as waiting nor resets the count
                    if (w_grant_f || !bus.fetch_req) begin
                        r_starve_cnt <= '0;
                    end else if (w_grant_d && w_fetch_live && !w_starved) begin
                        r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
                    end
                end
                BUSY_F, BUSY_D: begin
                    r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                    if (r_state == BUSY_F && bus.fetch_flush) begin
                        r_cancel <= 1'b1;
                    end
                    if (w_last) begin
                        r_state       <= IDLE;
                        r_busy        <= 1'b0;
                        r_mem_address <= '0;
                        r_mem_wdata   <= '0;
                        r_cancel      <= 1'b0;
                        if (r_state == BUSY_F) begin
                            if (!r_cancel && !bus.fetch_flush) begin
                                r_fetch_rdata <= bus.mem_read_value;
                                r_fetch_ready <= 1'b1;
                            end
                        end else begin
                            r_data_ready <= 1'b1;
                            if (!r_is_write) begin
                                r_data_rdata <= bus.mem_read_value;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.fetch_ready = r_fetch_ready;
    assign bus.fetch_rdata = r_fetch_rdata;
    assign bus.data_ready  = r_data_ready;
    assign bus.data_rdata  = r_data_rdata;
    assign bus.mem_address = r_mem_address;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.busy        = r_busy;
endmodule
